// File: rtl/mcu_pixel_streamer_if.sv
// Handshake/bus bundle between the MCU mux, the pixel streamer and the frame-buffer writer.
// master = streamer side (drives mux select and the pixel stream), slave = mux/writer side.
interface mcu_pixel_streamer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [10:0]           mcu_sel;
    logic [7:0][7:0][31:0] mcu_in;
    logic [31:0]           pix_data;
    logic [ADDR_W-1:0]     pix_addr;
    logic                  pix_valid;
    logic                  pix_ready;

    modport master (
        output mcu_sel, pix_data, pix_addr, pix_valid,
        input  mcu_in, pix_ready
    );

    modport slave (
        input  mcu_sel, pix_data, pix_addr, pix_valid,
        output mcu_in, pix_ready
    );
endinterface

// File: rtl/mcu_pixel_streamer.sv
// Walks the MCU mux over a frame, latches each 8x8 block and streams it in raster-address order.
// Optional macro PIX_CLAMP_EN: clamp signed samples to [0,255] as they are latched.
module mcu_pixel_streamer #(
    parameter int unsigned NUM_MCU      = 28,
    parameter int unsigned MCUS_PER_ROW = 7,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    mcu_pixel_streamer_if.master bus,
    output logic                 busy,
    output logic                 done
);
    // Address steps: next pixel row inside a block, next block right, next block band down.
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(MCUS_PER_ROW * 8 - 7);
    localparam logic [ADDR_W-1:0] MCU_STEP  = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(MCUS_PER_ROW * 64 - (MCUS_PER_ROW - 1) * 8);
    localparam logic [10:0]       LAST_MCU  = 11'(NUM_MCU - 1);
    localparam logic [10:0]       LAST_COL  = 11'(MCUS_PER_ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    state_t                state_q;
    logic [10:0]           idx_q;
    logic [10:0]           mcol_q;
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2:0]            r_q;
    logic [2:0]            c_q;
    logic [7:0][7:0][31:0] blk_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    function automatic logic [31:0] shape_sample(input logic [31:0] s);
`ifdef PIX_CLAMP_EN
        if (s[31]) return '0;
        if (s > 32'd255) return 32'd255;
        return s;
`else
        return s;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mcol_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            blk_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        state_q <= S_LOAD;
                        idx_q   <= '0;
                        mcol_q  <= '0;
                        base_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        for (int unsigned j = 0; j < 8; j++) begin
                            blk_q[i][j] <= shape_sample(bus.mcu_in[i][j]);
                        end
                    end
                    r_q     <= '0;
                    c_q     <= '0;
                    addr_q  <= base_q;
                    valid_q <= 1'b1;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (bus.pix_ready) begin
                        if (c_q != 3'd7) begin
                            c_q    <= c_q + 3'd1;
                            addr_q <= addr_q + 1'b1;
                        end else if (r_q != 3'd7) begin
                            c_q    <= '0;
                            r_q    <= r_q + 3'd1;
                            addr_q <= addr_q + ROW_STEP;
                        end else begin
                            valid_q <= 1'b0;
                            if (idx_q == LAST_MCU) begin
                                state_q <= S_DONE;
                                idx_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_LOAD;
                                idx_q   <= idx_q + 11'd1;
                                // Block base walks right, then wraps to the next 8-row band.
                                if (mcol_q == LAST_COL) begin
                                    mcol_q <= '0;
                                    base_q <= base_q + BAND_STEP;
                                end else begin
                                    mcol_q <= mcol_q + 11'd1;
                                    base_q <= base_q + MCU_STEP;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mcu_sel   = idx_q;
    assign bus.pix_data  = blk_q[r_q][c_q];
    assign bus.pix_addr  = addr_q;
    assign bus.pix_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_mcu_pixel_streamer.sv
// Self-checking bench for mcu_pixel_streamer: raster-order scoreboard plus directed scenarios.
module tb_mcu_pixel_streamer;
    localparam int NUM_MCU = 28;
    localparam int MPR     = 7;
    localparam int ADDR_W  = 16;
    localparam int TOTAL   = NUM_MCU * 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    mcu_pixel_streamer_if #(.ADDR_W(ADDR_W)) bus();

    mcu_pixel_streamer #(
        .NUM_MCU(NUM_MCU),
        .MCUS_PER_ROW(MPR),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sb_idx = 0;
    int mode = 0;
    int rmode = 0;
    int stall_cnt = 0;
    bit stalled = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0] first4 [4];
    int addr8 = -1;
    int last_addr = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source block content the mux presents for MCU k.
    function automatic logic [31:0] src(input int m, input int k, input int r, input int c);
        if (m == 0) return 32'((k << 16) | (r << 3) | c);
        if (c < 4) begin
            case (c)
                0:       return 32'hFFFF_FFFB;
                1:       return 32'd300;
                2:       return 32'd128;
                default: return 32'h7FFF_FFFF;
            endcase
        end
        return 32'(k * 9 + r * 40 - 100);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] s);
`ifdef PIX_CLAMP_EN
        int v;
        v = $signed(s);
        if (v < 0) return 32'd0;
        if (v > 255) return 32'd255;
        return s;
`else
        return s;
`endif
    endfunction

    // Mux model; content is scrambled whenever the streamer is not loading.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                bus.mcu_in[r][c] = src(mode, int'(bus.mcu_sel), r, c)
                                 ^ (bus.pix_valid ? 32'hA5A5_5A5A : 32'h0);
            end
        end
    end

    initial bus.pix_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rmode == 0) begin
            bus.pix_ready = 1'b1;
        end else if (stall_cnt > 0) begin
            bus.pix_ready = 1'b0;
            stall_cnt--;
        end else if (!stalled && sb_idx >= 3 * 64 + 20) begin
            stalled = 1'b1;
            stall_cnt = 9;
            bus.pix_ready = 1'b0;
        end else begin
            bus.pix_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        int k, r, c;
        if (!rst_n) begin
            sb_idx = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.pix_valid, 1);
                chk("hold_data", bus.pix_data, prev_data);
                chk("hold_addr", bus.pix_addr, prev_addr);
            end
            if (bus.pix_valid) begin
                chk("busy_with_valid", busy, 1);
                if (bus.pix_ready) begin
                    if (sb_idx >= TOTAL) begin
                        chk("overrun", sb_idx, TOTAL - 1);
                    end else begin
                        k = sb_idx / 64;
                        r = (sb_idx / 8) % 8;
                        c = sb_idx % 8;
                        chk("pix_data", bus.pix_data, exp_data(src(mode, k, r, c)));
                        chk("pix_addr", bus.pix_addr,
                            ((k / MPR) * 8 + r) * (MPR * 8) + (k % MPR) * 8 + c);
                        chk("mcu_sel", bus.mcu_sel, k);
                        if (sb_idx < 4) first4[sb_idx] = bus.pix_data;
                        if (sb_idx == 8 * 64) addr8 = int'(bus.pix_addr);
                        if (sb_idx == TOTAL - 1) last_addr = int'(bus.pix_addr);
                        sb_idx++;
                    end
                end
            end
            if (done) chk("samples_at_done", sb_idx, TOTAL);
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_data  = bus.pix_data;
            prev_addr  = bus.pix_addr;
        end
    end

    // Entered and left at a negedge. cyc counts posedges including the one that samples start.
    task automatic run_frame(input bit extra, output int cyc, output int dn,
                             output int busy_drop, output int busy_post);
        bit pulsed;
        pulsed = 1'b0;
        sb_idx = 0;
        dn = 0;
        busy_drop = 0;
        busy_post = 0;
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        while (dn == 0 && cyc < 6000) begin
            if (done) begin
                dn = 1;
            end else begin
                if (!busy) busy_drop++;
                if (extra && !pulsed && sb_idx >= 5 * 64 + 3) begin
                    start = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("done_seen", dn, 1);
        chk("busy_at_done", busy, 0);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dn++;
            if (busy) busy_post++;
        end
    endtask

    initial begin
        int cyc, dn, bdrop, bpost, guard;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel", bus.mcu_sel, 0);
        chk("rst_addr", bus.pix_addr, 0);
        chk("rst_data", bus.pix_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, ready held high.
        run_frame(1'b0, cyc, dn, bdrop, bpost);
        chk("frameA_cycles", cyc, 1821);
        chk("frameA_done_pulses", dn, 1);
        chk("frameA_busy_drop", bdrop, 0);
        chk("frameA_busy_post", bpost, 0);
        chk("frameA_samples", sb_idx, TOTAL);
        chk("addr_mcu8_r0c0", addr8, 456);
        chk("last_addr", last_addr, 1791);

        // Backpressure with a 10-cycle stall in MCU 3 and a stray start in MCU 5.
        rmode = 1;
        run_frame(1'b1, cyc, dn, bdrop, bpost);
        chk("frameB_done_pulses", dn, 1);
        chk("frameB_busy_drop", bdrop, 0);
        chk("frameB_busy_post", bpost, 0);
        chk("frameB_samples", sb_idx, TOTAL);
        chk("frameB_stall_hit", stalled, 1);
        rmode = 0;
        @(negedge clk);

        // Asynchronous abort in MCU 12.
        sb_idx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (sb_idx < 12 * 64 + 10 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_reached_mcu12", guard < 3000, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.pix_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sel", bus.mcu_sel, 0);
        chk("abort_addr", bus.pix_addr, 0);
        chk("abort_data", bus.pix_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_done", done, 0);

        // Fresh frame from MCU 0 with signed/out-of-range samples.
        mode = 1;
        run_frame(1'b0, cyc, dn, bdrop, bpost);
        chk("frameD_cycles", cyc, 1821);
        chk("frameD_done_pulses", dn, 1);
        chk("frameD_samples", sb_idx, TOTAL);
`ifdef PIX_CLAMP_EN
        chk("clamp_neg5", first4[0], 32'd0);
        chk("clamp_300", first4[1], 32'd255);
        chk("clamp_128", first4[2], 32'd128);
        chk("clamp_max", first4[3], 32'd255);
`else
        chk("raw_neg5", first4[0], 32'hFFFF_FFFB);
        chk("raw_300", first4[1], 32'd300);
        chk("raw_128", first4[2], 32'd128);
        chk("raw_max", first4[3], 32'h7FFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
